// File: rtl/alu_seq.sv
// alu_seq - operand latch and operation sequencer in front of the ALU.
//
// Captures the operand/opcode sources on an accepted start request and holds them
// stable towards the ALU for the whole operation. Combinational ALU operations
// (add, sub, zero) get one settle cycle before capture. A multiply pulses init for
// one cycle and waits for alu_done, aborting with err_timeout after TIMEOUT cycles.
// The ALU result and flags are then registered into res_q/flags_q with res_valid.
//
// Build option:
//   ALU_SEQ_SYNC_EN  when defined, start passes a 2-flop synchronizer and a
//                    rising-edge detector (one operation per 0->1 of start, +2
//                    cycles latency). When undefined, start is used directly and
//                    is level-sensitive in IDLE.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active low
//   start        operation request
//   a_in, b_in   operand sources (W_OPD)
//   op_in        opcode source: 00 add, 01 sub, 10 mul, 11 zero
//   sel_in       subtractor mode source
//   A, B, OP     latched operands/opcode to the ALU
//   sel          latched subtractor mode to the ALU
//   init         one-cycle multiplier start pulse
//   alu_done     multiplier done from the ALU
//   alu_resul    ALU result (W_RES)
//   alu_signo    ALU sign flag
//   alu_cout     ALU subtract carry
//   alu_cout_s   ALU add carry
//   busy         operation in progress
//   res_q        captured result
//   flags_q      captured {signo, cout, cout_s}
//   res_valid    res_q holds the result of the last completed operation
//   err_timeout  last multiply aborted on timeout
module alu_seq #(
  parameter int unsigned W_OPD   = 4,
  parameter int unsigned W_RES   = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W_OPD-1:0] a_in,
  input  logic [W_OPD-1:0] b_in,
  input  logic [1:0]       op_in,
  input  logic             sel_in,
  output logic [W_OPD-1:0] A,
  output logic [W_OPD-1:0] B,
  output logic [1:0]       OP,
  output logic             sel,
  output logic             init,
  input  logic             alu_done,
  input  logic [W_RES-1:0] alu_resul,
  input  logic             alu_signo,
  input  logic             alu_cout,
  input  logic             alu_cout_s,
  output logic             busy,
  output logic [W_RES-1:0] res_q,
  output logic [2:0]       flags_q,
  output logic             res_valid,
  output logic             err_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StSettle   = 3'd2,
    StMulStart = 3'd3,
    StMulWait  = 3'd4,
    StCapture  = 3'd5
  } state_e;

  state_e r_state;
  state_e w_state_d;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  logic             w_start_q;
  logic             w_accept;
  logic             w_capture;
  logic             w_abort;

  logic [W_OPD-1:0] r_a;
  logic [W_OPD-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_sel;
  logic             r_init;
  logic             r_busy;
  logic [W_RES-1:0] r_res;
  logic [2:0]       r_flags;
  logic             r_res_valid;
  logic             r_err;

  // ---------------------------------------------------------------------------
  // Start qualification
  // ---------------------------------------------------------------------------
`ifdef ALU_SEQ_SYNC_EN
  logic [1:0] r_start_sync;
  logic       r_start_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_sync <= 2'b00;
      r_start_prev <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[0], start};
      r_start_prev <= r_start_sync[1];
    end
  end

  // One pulse per rising edge of the synchronized button.
  assign w_start_q = r_start_sync[1] & ~r_start_prev;
`else
  assign w_start_q = start;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_start_q) begin
          w_accept  = 1'b1;
          w_state_d = StLoad;
        end
      end
      StLoad: begin
        w_state_d = (r_op == OP_MUL) ? StMulStart : StSettle;
      end
      StSettle: begin
        w_state_d = StCapture;
      end
      StMulStart: begin
        w_cnt_d   = '0;
        w_state_d = StMulWait;
      end
      StMulWait: begin
        if (alu_done) begin
          w_state_d = StCapture;
        end else if (r_cnt == CNT_LAST) begin
          w_abort   = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StCapture: begin
        w_capture = 1'b1;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand latch, init pulse and result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 2'b00;
      r_sel       <= 1'b0;
      r_init      <= 1'b0;
      r_busy      <= 1'b0;
      r_res       <= '0;
      r_flags     <= 3'b000;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Registered from the next state so init is high exactly while in
      // MUL_START and comes straight off a flop.
      r_init <= (w_state_d == StMulStart);

      if (w_accept) begin
        r_a         <= a_in;
        r_b         <= b_in;
        r_op        <= op_in;
        r_sel       <= sel_in;
        r_busy      <= 1'b1;
        r_res_valid <= 1'b0;
        r_err       <= 1'b0;
      end

      if (w_capture) begin
        r_res       <= alu_resul;
        r_flags     <= {alu_signo, alu_cout, alu_cout_s};
        r_res_valid <= 1'b1;
        r_busy      <= 1'b0;
      end

      // Abort leaves res_q untouched and res_valid low (cleared on accept).
      if (w_abort) begin
        r_err  <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign A           = r_a;
  assign B           = r_b;
  assign OP          = r_op;
  assign sel         = r_sel;
  assign init        = r_init;
  assign busy        = r_busy;
  assign res_q       = r_res;
  assign flags_q     = r_flags;
  assign res_valid   = r_res_valid;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int unsigned W_OPD   = 4;
  localparam int unsigned W_RES   = 6;
  localparam int unsigned TIMEOUT = 64;
`ifdef ALU_SEQ_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [W_OPD-1:0] a_in, b_in;
  logic [1:0]       op_in;
  logic             sel_in;
  logic [W_OPD-1:0] a_o, b_o;
  logic [1:0]       op_o;
  logic             sel_o;
  logic             init;
  logic             alu_done;
  logic [W_RES-1:0] alu_resul;
  logic             alu_signo, alu_cout, alu_cout_s;
  logic             busy;
  logic [W_RES-1:0] res_q;
  logic [2:0]       flags_q;
  logic             res_valid;
  logic             err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int done_delay = 0;  // 0: never raise alu_done

  always #5 clk = ~clk;

  alu_seq #(.W_OPD(W_OPD), .W_RES(W_RES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .op_in(op_in), .sel_in(sel_in), .A(a_o), .B(b_o), .OP(op_o), .sel(sel_o),
    .init(init), .alu_done(alu_done), .alu_resul(alu_resul), .alu_signo(alu_signo),
    .alu_cout(alu_cout), .alu_cout_s(alu_cout_s), .busy(busy), .res_q(res_q),
    .flags_q(flags_q), .res_valid(res_valid), .err_timeout(err_timeout)
  );

  // Behavioural ALU: returns {signo, cout, cout_s, result[5:0]}.
  // sub: sel=1 -> A-B, sel=0 -> B-A; result is the magnitude, signo marks negative.
  function automatic logic [8:0] alu_ref(input int a, input int b, input int op, input int s);
    int d;
    case (op)
      0: begin d = a + b; return {1'b0, 1'b0, (d > 15), 6'(d)}; end
      1: begin
        d = (s != 0) ? a - b : b - a;
        if (d < 0) return {1'b1, 1'b0, 1'b0, 6'(-d)};
        return {1'b0, 1'b1, 1'b0, 6'(d)};
      end
      2: return {3'b000, 6'(a * b)};
      default: return 9'd0;
    endcase
  endfunction

  logic [8:0] alu_w;
  always_comb begin
    alu_w      = alu_ref(int'(a_o), int'(b_o), int'(op_o), int'(sel_o));
    alu_resul  = alu_w[5:0];
    alu_cout_s = alu_w[6];
    alu_cout   = alu_w[7];
    alu_signo  = alu_w[8];
  end

  // Multiplier model: alu_done pulses done_delay cycles after init is seen.
  initial begin
    alu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (init === 1'b1 && done_delay > 0) begin
        repeat (done_delay) @(negedge clk);
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a one-cycle start pulse; returns at the negedge after the pulse.
  task automatic kick(input int a, input int b, input int op, input int s);
    a_in = W_OPD'(a); b_in = W_OPD'(b); op_in = 2'(op); sel_in = s[0];
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; op_in = 2'b00; sel_in = 1'b0;
    step(3);
    n_checks++;
    if ({init, busy, res_valid, err_timeout} !== 4'b0000 || a_o !== 4'd0 || res_q !== 6'd0
        || flags_q !== 3'd0 || op_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: init/busy/valid/err=%b A=%0d res=%0d flags=%b, need all 0",
               {init, busy, res_valid, err_timeout}, a_o, res_q, flags_q);
    end
    rst_n = 1'b1;
    step(1);
    // Reset in the middle of a multiply wait.
    done_delay = 0;
    kick(9, 9, 2, 0);
    step(3 + S);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_busy: busy=%b, need 1", busy);
    end
    rst_n = 1'b0;
    step(2);
    n_checks++;
    if ({init, busy, res_valid, err_timeout} !== 4'b0000 || a_o !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mul: init/busy/valid/err=%b A=%0d, need 0", 
               {init, busy, res_valid, err_timeout}, a_o);
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_add();
    kick(5, 6, 0, 0);  // now at n0+1
    step(S);
    n_checks++;
    if (a_o !== 4'd5 || b_o !== 4'd6 || op_o !== 2'd0) begin
      n_fail++; $display("FAIL add_latch: A=%0d B=%0d OP=%0d, need 5 6 0", a_o, b_o, op_o);
    end
    step(2);  // n0+3
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL add_early: valid=%b busy=%b, need 0 1", res_valid, busy);
    end
    step(1);  // n0+4
    n_checks++;
    if (res_valid !== 1'b1 || busy !== 1'b0 || res_q !== 6'd11 || flags_q !== 3'b000) begin
      n_fail++;
      $display("FAIL add_result: valid=%b busy=%b res=%0d flags=%b, need 1 0 11 000",
               res_valid, busy, res_q, flags_q);
    end
    step(1);
  endtask

  task automatic test_sub_zero();
    kick(3, 7, 1, 1);
    step(3 + S);
    n_checks++;
    if (res_valid !== 1'b1 || res_q !== 6'd4 || flags_q !== 3'b100 || sel_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_result: valid=%b res=%0d flags=%b sel=%b, need 1 4 100 1",
               res_valid, res_q, flags_q, sel_o);
    end
    step(1);
    kick(9, 9, 3, 0);
    step(3 + S);
    n_checks++;
    if (res_valid !== 1'b1 || res_q !== 6'd0 || flags_q !== 3'b000) begin
      n_fail++;
      $display("FAIL zero_result: valid=%b res=%0d flags=%b, need 1 0 000",
               res_valid, res_q, flags_q);
    end
    step(1);
  endtask

  task automatic test_mul();
    int n_init = 0, first_init = -1, first_valid = -1;
    done_delay = 5;
    a_in = 4'd3; b_in = 4'd5; op_in = 2'b10; sel_in = 1'b0; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (init === 1'b1) begin
        n_init++;
        if (first_init < 0) first_init = k;
      end
      if (res_valid === 1'b1) begin
        first_valid = k;
        break;
      end
    end
    n_checks++;
    if (n_init != 1 || first_init != 2 + S) begin
      n_fail++;
      $display("FAIL mul_init: pulses=%0d at=%0d, need 1 at %0d", n_init, first_init, 2 + S);
    end
    n_checks++;
    if (first_valid != 4 + S + 5) begin
      n_fail++; $display("FAIL mul_latency: valid at %0d, need %0d", first_valid, 9 + S);
    end
    n_checks++;
    if (res_q !== 6'd15 || busy !== 1'b0 || err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_result: res=%0d busy=%b err=%b, need 15 0 0", res_q, busy, err_timeout);
    end
    step(1);
  endtask

  task automatic test_timeout();
    done_delay = 0;
    kick(1, 1, 2, 0);
    step(1 + TIMEOUT + S);  // n0+2+T: last MUL_WAIT cycle
    n_checks++;
    if (busy !== 1'b1 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: busy=%b err=%b, need 1 0", busy, err_timeout);
    end
    step(1);
    n_checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || res_q !== 6'd15) begin
      n_fail++;
      $display("FAIL timeout_abort: err=%b busy=%b valid=%b res=%0d, need 1 0 0 15",
               err_timeout, busy, res_valid, res_q);
    end
    step(1);
  endtask

  task automatic test_busy_ignore();
    int seen = 0;
    done_delay = 5;
    kick(2, 7, 2, 0);
    step(2);
    a_in = 4'd9; op_in = 2'b00; start = 1'b1;
    step(1);
    start = 1'b0;
    n_checks++;
    if (a_o !== 4'd2 || op_o !== 2'b10) begin
      n_fail++; $display("FAIL busy_latch: A=%0d OP=%0d, need 2 2", a_o, op_o);
    end
    for (int k = 0; k < 40; k++) begin
      if (res_valid === 1'b1) begin seen = 1; break; end
      step(1);
    end
    n_checks++;
    if (seen != 1 || res_q !== 6'd14) begin
      n_fail++; $display("FAIL busy_result: seen=%0d res=%0d, need 1 14", seen, res_q);
    end
    step(3 + S);
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b1 || a_o !== 4'd2) begin
      n_fail++;
      $display("FAIL busy_not_queued: busy=%b valid=%b A=%0d, need 0 1 2", busy, res_valid, a_o);
    end
  endtask

  task automatic test_held_start();
    int seen = 0;
    a_in = 4'd4; b_in = 4'd4; op_in = 2'b00; sel_in = 1'b0; start = 1'b1;
    step(4 + S);
    n_checks++;
    if (res_valid !== 1'b1 || res_q !== 6'd8) begin
      n_fail++; $display("FAIL held_first: valid=%b res=%0d, need 1 8", res_valid, res_q);
    end
    step(1);
`ifdef ALU_SEQ_SYNC_EN
    step(4);
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b1) begin
      n_fail++; $display("FAIL held_once: busy=%b valid=%b, need 0 1", busy, res_valid);
    end
    start = 1'b0;
`else
    n_checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL held_retrigger: busy=%b valid=%b, need 1 0", busy, res_valid);
    end
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (res_valid === 1'b1) begin seen = 1; break; end
      step(1);
    end
    n_checks++;
    if (seen != 1) begin
      n_fail++; $display("FAIL held_second: valid=%b, need 1", res_valid);
    end
`endif
    step(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int a = $urandom_range(0, 15);
      int b = $urandom_range(0, 15);
      int op = $urandom_range(0, 3);
      int s = $urandom_range(0, 1);
      int seen = 0;
      logic [8:0] exp;
      done_delay = $urandom_range(1, 6);
      exp = alu_ref(a, b, op, s);
      kick(a, b, op, s);
      for (int k = 0; k < 40; k++) begin
        if (res_valid === 1'b1) begin seen = 1; break; end
        step(1);
      end
      n_checks++;
      if (seen != 1 || res_q !== exp[5:0] || flags_q !== exp[8:6]
          || a_o !== W_OPD'(a) || b_o !== W_OPD'(b) || op_o !== 2'(op) || sel_o !== s[0]) begin
        n_fail++;
        $display("FAIL random_%0d: a=%0d b=%0d op=%0d sel=%0d got res=%0d flags=%b seen=%0d, need res=%0d flags=%b",
                 i, a, b, op, s, res_q, flags_q, seen, exp[5:0], exp[8:6]);
      end
      step(1);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_zero();
    test_mul();
    test_timeout();
    test_busy_ignore();
    test_held_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
